xadac_vdot_unit: RTL and testbench

//   Parametrised, pipelined vector dot-product/MAC engine for the XADAC coprocessor.
//   Per request: splits two VectorWidth operands into NumElems = VectorWidth/ElemWidth lanes,

---
 rtl/xadac_vdot_unit.sv | 156 +++++++++++++++
 tb/tb_xadac_vdot_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xadac_vdot_unit.sv
// Pipelined lane-wise multiply / reduce / accumulate engine for the XADAC coprocessor.
// S1 registers the exact lane products; S2 registers the reduced, optionally saturated result.
module xadac_vdot_unit #(
  parameter int unsigned VectorWidth = 128,
  parameter int unsigned ElemWidth   = 8,
  parameter int unsigned SumWidth    = 32,
  parameter int unsigned IdWidth     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic [VectorWidth-1:0] req_a_i,
  input  logic [VectorWidth-1:0] req_b_i,
  input  logic [SumWidth-1:0]    req_acc_i,
  input  logic                   req_a_signed_i,
  input  logic                   req_b_signed_i,
  input  logic                   req_acc_en_i,
  input  logic                   req_sat_en_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic [SumWidth-1:0]    resp_sum_o
);

  localparam int unsigned NumElems  = VectorWidth / ElemWidth;
  localparam int unsigned ExtWidth  = ElemWidth + 1;
  localparam int unsigned ProdWidth = 2 * ElemWidth + 2;
  localparam int unsigned FullWidth = SumWidth + $clog2(NumElems) + 1;

  // Largest / smallest value representable in a signed SumWidth result, held at full width.
  localparam logic signed [FullWidth-1:0] SatMax =
    {{(FullWidth - SumWidth + 1){1'b0}}, {(SumWidth - 1){1'b1}}};
  localparam logic signed [FullWidth-1:0] SatMin = ~SatMax;

  if ((VectorWidth % ElemWidth) != 0) begin : g_bad_vector_width
    $error("xadac_vdot_unit: VectorWidth must be a multiple of ElemWidth");
  end
  if (SumWidth < (2 * ElemWidth + 2)) begin : g_bad_sum_width
    $error("xadac_vdot_unit: SumWidth must be at least 2*ElemWidth+2");
  end

  logic                        s1_valid_q, s1_valid_d;
  logic [IdWidth-1:0]          s1_id_q, s1_id_d;
  logic signed [ProdWidth-1:0] s1_prod_q [NumElems];
  logic signed [ProdWidth-1:0] s1_prod_d [NumElems];
  logic signed [SumWidth-1:0]  s1_acc_q, s1_acc_d;
  logic                        s1_sat_q, s1_sat_d;

  logic                        s2_valid_q, s2_valid_d;
  logic [IdWidth-1:0]          s2_id_q, s2_id_d;
  logic [SumWidth-1:0]         s2_sum_q, s2_sum_d;

  logic                        s2_adv, s2_free, s1_adv, accept;
  logic [ElemWidth-1:0]        a_lane, b_lane;
  logic signed [ExtWidth-1:0]  a_ext, b_ext;
  logic signed [FullWidth-1:0] full_sum;

  // Two-slot valid/ready pipeline; ready looks only at downstream state, never at req_valid_i.
  always_comb begin : handshake
    s2_adv  = s2_valid_q & resp_ready_i;
    s2_free = ~s2_valid_q | s2_adv;
    s1_adv  = s1_valid_q & s2_free;
    accept  = req_valid_i & (~s1_valid_q | s1_adv);
  end

  assign req_ready_o  = ~s1_valid_q | s1_adv;
  assign resp_valid_o = s2_valid_q;
  assign resp_id_o    = s2_id_q;
  assign resp_sum_o   = s2_sum_q;

  // S1 next state: per-lane extension to ElemWidth+1 bits, exact signed products.
  always_comb begin : s1_next
    a_lane     = '0;
    b_lane     = '0;
    a_ext      = '0;
    b_ext      = '0;
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_acc_d   = s1_acc_q;
    s1_sat_d   = s1_sat_q;
    for (int unsigned k = 0; k < NumElems; k++) begin
      s1_prod_d[k] = s1_prod_q[k];
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_id_d    = req_id_i;
      s1_acc_d   = req_acc_en_i ? req_acc_i : '0;
      s1_sat_d   = req_sat_en_i;
      for (int unsigned k = 0; k < NumElems; k++) begin
        a_lane       = req_a_i[k*ElemWidth +: ElemWidth];
        b_lane       = req_b_i[k*ElemWidth +: ElemWidth];
        a_ext        = {req_a_signed_i & a_lane[ElemWidth-1], a_lane};
        b_ext        = {req_b_signed_i & b_lane[ElemWidth-1], b_lane};
        s1_prod_d[k] = ProdWidth'(a_ext) * ProdWidth'(b_ext);
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: exact reduction at FullWidth, then wrap or clamp to SumWidth.
  always_comb begin : s2_next
    full_sum = FullWidth'(s1_acc_q);
    for (int unsigned k = 0; k < NumElems; k++) begin
      full_sum = full_sum + FullWidth'(s1_prod_q[k]);
    end

    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_sum_d   = s2_sum_q;

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_id_q;
      if (s1_sat_q && (full_sum > SatMax)) begin
        s2_sum_d = {1'b0, {(SumWidth - 1){1'b1}}};
      end else if (s1_sat_q && (full_sum < SatMin)) begin
        s2_sum_d = {1'b1, {(SumWidth - 1){1'b0}}};
      end else begin
        s2_sum_d = full_sum[SumWidth-1:0];
      end
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : regs
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_acc_q   <= '0;
      s1_sat_q   <= 1'b0;
      for (int unsigned k = 0; k < NumElems; k++) begin
        s1_prod_q[k] <= '0;
      end
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_acc_q   <= s1_acc_d;
      s1_sat_q   <= s1_sat_d;
      for (int unsigned k = 0; k < NumElems; k++) begin
        s1_prod_q[k] <= s1_prod_d[k];
      end
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

endmodule

// File: tb/tb_xadac_vdot_unit.sv
// Scoreboard bench for xadac_vdot_unit: a default 8-bit-lane instance and a 16-bit-lane instance.
module tb_xadac_vdot_unit;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] sum;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_valid_i, req2_valid_i;
  logic         req_ready_o, req2_ready_o;
  logic [3:0]   req_id_i;
  logic [127:0] req_a_i, req_b_i;
  logic [31:0]  req_acc_i;
  logic [33:0]  req2_acc_i;
  logic         req_a_signed_i, req_b_signed_i, req_acc_en_i, req_sat_en_i;
  logic         resp_valid_o, resp_ready_i, resp2_valid_o, resp2_ready_i;
  logic [3:0]   resp_id_o, resp2_id_o;
  logic [31:0]  resp_sum_o;
  logic [33:0]  resp2_sum_o;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  exp_t q  [$];
  exp_t q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xadac_vdot_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_acc_i(req_acc_i),
    .req_a_signed_i(req_a_signed_i), .req_b_signed_i(req_b_signed_i),
    .req_acc_en_i(req_acc_en_i), .req_sat_en_i(req_sat_en_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_sum_o(resp_sum_o)
  );

  xadac_vdot_unit #(.VectorWidth(128), .ElemWidth(16), .SumWidth(34), .IdWidth(4)) dut16 (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req2_valid_i), .req_ready_o(req2_ready_o), .req_id_i(req_id_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_acc_i(req2_acc_i),
    .req_a_signed_i(req_a_signed_i), .req_b_signed_i(req_b_signed_i),
    .req_acc_en_i(req_acc_en_i), .req_sat_en_i(req_sat_en_i),
    .resp_valid_o(resp2_valid_o), .resp_ready_i(resp2_ready_i),
    .resp_id_o(resp2_id_o), .resp_sum_o(resp2_sum_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  function automatic logic [127:0] rep8(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [127:0] rep16(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input bit sel, input logic [3:0] id, input logic [127:0] a,
                       input logic [127:0] b, input logic [63:0] acc, input bit as,
                       input bit bs, input bit ae, input bit se,
                       input logic [63:0] exp_sum, input bit lat);
    bit   got;
    exp_t e;
    req_id_i = id; req_a_i = a; req_b_i = b;
    req_acc_i = acc[31:0]; req2_acc_i = acc[33:0];
    req_a_signed_i = as; req_b_signed_i = bs; req_acc_en_i = ae; req_sat_en_i = se;
    if (sel) req2_valid_i = 1'b1; else req_valid_i = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if ((sel ? req2_ready_o : req_ready_o) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      e.id = id; e.sum = exp_sum; e.acc_cyc = cyc; e.chk_lat = lat;
      if (sel) q2.push_back(e); else q.push_back(e);
    end else begin
      fail("accept_timeout");
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0; req2_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (q.size() == 0 && q2.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) fail("drain_timeout");
  endtask

  // Monitor for the 8-bit instance: compares on transfer, checks hold-stability while stalled.
  bit          seen, held;
  int          first_cyc;
  logic [3:0]  held_id;
  logic [31:0] held_sum;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      seen = 1'b0; held = 1'b0;
    end else if (resp_valid_o) begin
      if (!seen) begin seen = 1'b1; first_cyc = cyc; end
      if (held) begin
        check("stable_id", 64'(resp_id_o), 64'(held_id));
        check("stable_sum", 64'(resp_sum_o), 64'(held_sum));
      end
      if (resp_ready_i) begin
        if (q.size() == 0) fail("unexpected_resp");
        else begin
          e = q.pop_front();
          check("resp_id", 64'(resp_id_o), 64'(e.id));
          check("resp_sum", 64'(resp_sum_o), e.sum);
          if (e.chk_lat) check("latency", 64'(first_cyc - e.acc_cyc), 64'd2);
        end
        seen = 1'b0; held = 1'b0;
      end else begin
        held = 1'b1; held_id = resp_id_o; held_sum = resp_sum_o;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && resp2_valid_o && resp2_ready_i) begin
      if (q2.size() == 0) fail("unexpected_resp16");
      else begin
        e = q2.pop_front();
        check("resp16_id", 64'(resp2_id_o), 64'(e.id));
        check("resp16_sum", 64'(resp2_sum_o), e.sum);
      end
    end
  end

  initial begin
    logic [127:0] idx;
    rst_i = 1'b1; req_valid_i = 1'b0; req2_valid_i = 1'b0; req_id_i = '0;
    req_a_i = '0; req_b_i = '0; req_acc_i = '0; req2_acc_i = '0;
    req_a_signed_i = 1'b0; req_b_signed_i = 1'b0; req_acc_en_i = 1'b0; req_sat_en_i = 1'b0;
    resp_ready_i = 1'b1; resp2_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_resp_id", 64'(resp_id_o), 64'd0);
    check("rst_resp_sum", 64'(resp_sum_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Basic arithmetic, first one with a latency check from an empty pipe.
    issue(0, 4'h1, rep8(8'hFF), rep8(8'hFF), 64'h0, 0, 0, 0, 0, 64'h000FE010, 1);
    drain();
    issue(0, 4'h2, rep8(8'hFF), rep8(8'h02), 64'h0, 1, 0, 0, 0, 64'hFFFFFFE0, 0);
    issue(0, 4'h3, rep8(8'h01), rep8(8'h01), 64'h7FFFFFF0, 0, 0, 1, 1, 64'h7FFFFFFF, 0);
    issue(0, 4'h4, rep8(8'h01), rep8(8'h01), 64'h7FFFFFF0, 0, 0, 1, 0, 64'h80000000, 0);
    issue(0, 4'h5, rep8(8'h80), rep8(8'hFF), 64'h80000000, 1, 0, 1, 1, 64'h80000000, 0);
    issue(0, 4'h6, rep8(8'h80), rep8(8'hFF), 64'h80000000, 1, 0, 1, 0, 64'h7FF80800, 0);
    issue(0, 4'h7, rep8(8'h01), rep8(8'h01), 64'h1234, 0, 0, 0, 0, 64'h10, 0);
    idx = '0;
    for (int k = 0; k < 16; k++) idx[k*8 +: 8] = 8'(k);
    issue(0, 4'h8, idx, rep8(8'h01), 64'h0, 0, 0, 0, 0, 64'h78, 0);
    issue(0, 4'h9, idx, idx, 64'h0, 0, 0, 0, 0, 64'h4D8, 0);
    drain();

    // Backpressure: two accepts fill the pipe, ready drops, release drains in order.
    resp_ready_i = 1'b0;
    issue(0, 4'h1, rep8(8'h01), rep8(8'h03), 64'h0, 0, 0, 0, 0, 64'h30, 0);
    issue(0, 4'h2, rep8(8'h10), rep8(8'h10), 64'h5, 0, 0, 1, 0, 64'h1005, 0);
    @(negedge clk);
    check("ready_drop", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1;
    fork
      begin repeat (4) @(posedge clk); #1; resp_ready_i = 1'b1; end
    join_none
    issue(0, 4'h3, rep8(8'h80), rep8(8'h80), 64'hFFFFFFFF, 1, 1, 1, 1, 64'h3FFFF, 0);
    drain();

    // Reset with both stages full: outputs clear at once, nothing emerges afterwards.
    resp_ready_i = 1'b0;
    issue(0, 4'hA, rep8(8'h02), rep8(8'h02), 64'h0, 0, 0, 0, 0, 64'h40, 0);
    issue(0, 4'hB, rep8(8'h03), rep8(8'h03), 64'h0, 0, 0, 0, 0, 64'h90, 0);
    rst_i = 1'b1;
    #1;
    check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("midrst_req_ready", 64'(req_ready_o), 64'd1);
    q.delete();
    @(posedge clk); #1;
    rst_i = 1'b0; resp_ready_i = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("post_rst_idle", 64'(resp_valid_o), 64'd0);

    // 16-bit lanes, 34-bit result: 8 x 2^30 = 2^33 just past the positive limit.
    issue(1, 4'hC, rep16(16'h8000), rep16(16'h8000), 64'h0, 1, 1, 0, 0, 64'h2_0000_0000, 0);
    issue(1, 4'hD, rep16(16'h8000), rep16(16'h8000), 64'h0, 1, 1, 0, 1, 64'h1_FFFF_FFFF, 0);
    issue(1, 4'hE, rep16(16'hFFFF), rep16(16'h0003), 64'h0, 1, 0, 0, 0, 64'h3_FFFF_FFE8, 0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
